// File: rtl/usb_std_req_ctrl.sv
// EP0 standard-request sequencer: SETUP capture, request decode, short IN replies,
// descriptor handoff and device state. Define REMOTE_WAKEUP_EN to add DEVICE_REMOTE_WAKEUP.
module usb_std_req_ctrl #(
  parameter logic [7:0] CONFIG_VALUE = 8'd1,
  parameter logic       SELF_POWERED = 1'b0
) (
  input  logic        clk48,
  input  logic        rst,
  input  logic        usbRst,
  input  logic        setupValid,
  input  logic [7:0]  setupByte,
  input  logic        setupEnd,
  output logic        inValid,
  input  logic        inReady,
  output logic [7:0]  inByte,
  output logic        inLast,
  output logic        descReq,
  output logic [7:0]  descType,
  output logic [7:0]  descIndex,
  output logic [15:0] descLen,
  input  logic        descDone,
  input  logic        descErr,
  input  logic        statusDone,
  output logic        reqStall,
  output logic [6:0]  devAddr,
  output logic [7:0]  devConfig,
`ifdef REMOTE_WAKEUP_EN
  output logic        remoteWakeupEn,
`endif
  output logic [1:0]  devState
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_DECODE, S_REPLY, S_DESC, S_WAIT_STATUS, S_APPLY
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE, OP_ADDR, OP_CFG, OP_RWK_SET, OP_RWK_CLR
  } op_e;

  localparam logic [1:0] DEV_DEFAULT    = 2'd0;
  localparam logic [1:0] DEV_ADDRESS    = 2'd1;
  localparam logic [1:0] DEV_CONFIGURED = 2'd2;

  localparam logic [7:0] REQ_GET_STATUS    = 8'd0;
  localparam logic [7:0] REQ_CLEAR_FEATURE = 8'd1;
  localparam logic [7:0] REQ_SET_FEATURE   = 8'd3;
  localparam logic [7:0] REQ_SET_ADDRESS   = 8'd5;
  localparam logic [7:0] REQ_GET_DESC      = 8'd6;
  localparam logic [7:0] REQ_GET_CONFIG    = 8'd8;
  localparam logic [7:0] REQ_SET_CONFIG    = 8'd9;

  logic rst_all;
  assign rst_all = rst | usbRst;

  state_e     state_q, state_d;
  logic [2:0] cnt_q;
  logic       full_q, ovf_q;
  logic [7:0] setup_q [8];
  logic       setup_ok;

  logic       stall_q;
  op_e        pend_op_q;
  logic [6:0] pend_addr_q;
  logic [7:0] pend_cfg_q;
  logic [7:0] rb0_q;
  logic       two_q, ridx_q;
  logic [6:0] dev_addr_q;
  logic [7:0] dev_cfg_q;
  logic [1:0] dev_state_q;
  logic       rwk;

  logic [7:0]  bm_type, b_req;
  logic [15:0] w_value, w_index, w_length;

  assign bm_type  = setup_q[0];
  assign b_req    = setup_q[1];
  assign w_value  = {setup_q[3], setup_q[2]};
  assign w_index  = {setup_q[5], setup_q[4]};
  assign w_length = {setup_q[7], setup_q[6]};

  // Exactly eight bytes since the last setupEnd makes a usable SETUP packet.
  assign setup_ok = full_q & ~ovf_q;

  always_ff @(posedge clk48) begin
    if (rst_all || setupEnd) begin
      cnt_q  <= 3'd0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (setupValid) begin
      cnt_q <= cnt_q + 3'd1;
      if (full_q) ovf_q <= 1'b1;
      if (cnt_q == 3'd7) full_q <= 1'b1;
    end
  end

  always_ff @(posedge clk48) begin
    if (setupValid && !full_q) setup_q[cnt_q] <= setupByte;
  end

  state_e     dec_state;
  logic       dec_stall;
  op_e        dec_op;
  logic [7:0] dec_b0;
  logic [1:0] dec_nat;

  always_comb begin
    dec_state = S_IDLE;
    dec_stall = 1'b1;
    dec_op    = OP_NONE;
    dec_b0    = 8'h00;
    dec_nat   = 2'd0;
    case ({bm_type, b_req})
      {8'h00, REQ_SET_ADDRESS}: begin
        if (w_value <= 16'd127 && dev_state_q != DEV_CONFIGURED) begin
          dec_stall = 1'b0;
          dec_op    = OP_ADDR;
          dec_state = S_WAIT_STATUS;
        end
      end
      {8'h00, REQ_SET_CONFIG}: begin
        if (dev_state_q != DEV_DEFAULT &&
            (w_value[7:0] == 8'h00 || w_value[7:0] == CONFIG_VALUE)) begin
          dec_stall = 1'b0;
          dec_op    = OP_CFG;
          dec_state = S_WAIT_STATUS;
        end
      end
      {8'h80, REQ_GET_CONFIG}: begin
        dec_stall = 1'b0;
        dec_nat   = 2'd1;
        dec_b0    = dev_cfg_q;
        dec_state = S_REPLY;
      end
      {8'h80, REQ_GET_STATUS}: begin
        dec_stall = 1'b0;
        dec_nat   = 2'd2;
        dec_b0    = {6'b0, rwk, SELF_POWERED};
        dec_state = S_REPLY;
      end
      {8'h81, REQ_GET_STATUS}, {8'h82, REQ_GET_STATUS}: begin
        if (w_index == 16'd0 || dev_state_q == DEV_CONFIGURED) begin
          dec_stall = 1'b0;
          dec_nat   = 2'd2;
          dec_state = S_REPLY;
        end
      end
      {8'h80, REQ_GET_DESC}: begin
        dec_stall = 1'b0;
        dec_state = S_DESC;
      end
      {8'h02, REQ_CLEAR_FEATURE}, {8'h02, REQ_SET_FEATURE}: begin
        // ENDPOINT_HALT on EP0 (either direction) is a harmless no-op.
        if (w_value == 16'd0 && w_index[6:0] == 7'd0) begin
          dec_stall = 1'b0;
          dec_state = S_WAIT_STATUS;
        end
      end
`ifdef REMOTE_WAKEUP_EN
      {8'h00, REQ_CLEAR_FEATURE}: begin
        if (w_value == 16'd1) begin
          dec_stall = 1'b0;
          dec_op    = OP_RWK_CLR;
          dec_state = S_WAIT_STATUS;
        end
      end
      {8'h00, REQ_SET_FEATURE}: begin
        if (w_value == 16'd1) begin
          dec_stall = 1'b0;
          dec_op    = OP_RWK_SET;
          dec_state = S_WAIT_STATUS;
        end
      end
`endif
      default: ;
    endcase
    if (dec_state == S_REPLY && w_length == 16'd0) dec_state = S_WAIT_STATUS;
  end

  always_ff @(posedge clk48) begin
    if (rst_all) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (setupEnd) begin
      state_d = setup_ok ? S_DECODE : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:        if (setupValid) state_d = S_COLLECT;
        S_COLLECT:     state_d = S_COLLECT;
        S_DECODE:      state_d = dec_state;
        S_REPLY:       if (inReady && (ridx_q == two_q)) state_d = S_WAIT_STATUS;
        S_DESC: begin
          if (descDone)     state_d = S_WAIT_STATUS;
          else if (descErr) state_d = S_IDLE;
        end
        S_WAIT_STATUS: if (statusDone) state_d = S_APPLY;
        S_APPLY:       state_d = S_IDLE;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    inValid   = 1'b0;
    inByte    = 8'h00;
    inLast    = 1'b0;
    descReq   = 1'b0;
    descType  = 8'h00;
    descIndex = 8'h00;
    descLen   = 16'h0000;
    case (state_q)
      S_REPLY: begin
        inValid = 1'b1;
        inByte  = ridx_q ? 8'h00 : rb0_q;
        inLast  = (ridx_q == two_q);
      end
      S_DESC: begin
        descReq   = 1'b1;
        descType  = w_value[15:8];
        descIndex = w_value[7:0];
        descLen   = w_length;
      end
      default: ;
    endcase
  end

  // Reply and pending-commit operands, captured while the request is decoded.
  always_ff @(posedge clk48) begin
    if (state_q == S_DECODE) begin
      rb0_q       <= dec_b0;
      two_q       <= (dec_nat == 2'd2) && (w_length >= 16'd2);
      pend_addr_q <= w_value[6:0];
      pend_cfg_q  <= w_value[7:0];
    end
  end

  always_ff @(posedge clk48) begin
    if (rst_all) begin
      stall_q     <= 1'b0;
      pend_op_q   <= OP_NONE;
      ridx_q      <= 1'b0;
      dev_addr_q  <= 7'd0;
      dev_cfg_q   <= 8'd0;
      dev_state_q <= DEV_DEFAULT;
    end else if (setupEnd) begin
      stall_q   <= ~setup_ok;
      pend_op_q <= OP_NONE;
    end else begin
      case (state_q)
        S_DECODE: begin
          stall_q   <= dec_stall;
          pend_op_q <= dec_op;
          ridx_q    <= 1'b0;
        end
        S_REPLY: if (inReady) ridx_q <= ~ridx_q;
        S_DESC:  if (!descDone && descErr) stall_q <= 1'b1;
        S_APPLY: begin
          case (pend_op_q)
            OP_ADDR: begin
              dev_addr_q  <= pend_addr_q;
              dev_state_q <= (pend_addr_q != 7'd0) ? DEV_ADDRESS : DEV_DEFAULT;
            end
            OP_CFG: begin
              dev_cfg_q   <= pend_cfg_q;
              dev_state_q <= (pend_cfg_q != 8'd0) ? DEV_CONFIGURED : DEV_ADDRESS;
            end
            default: ;
          endcase
          pend_op_q <= OP_NONE;
        end
        default: ;
      endcase
    end
  end

`ifdef REMOTE_WAKEUP_EN
  logic rwk_q;
  always_ff @(posedge clk48) begin
    if (rst_all) begin
      rwk_q <= 1'b0;
    end else if (!setupEnd && state_q == S_APPLY) begin
      if (pend_op_q == OP_RWK_SET)      rwk_q <= 1'b1;
      else if (pend_op_q == OP_RWK_CLR) rwk_q <= 1'b0;
    end
  end
  assign rwk            = rwk_q;
  assign remoteWakeupEn = rwk_q;
`else
  assign rwk = 1'b0;
`endif

  assign reqStall  = stall_q;
  assign devAddr   = dev_addr_q;
  assign devConfig = dev_cfg_q;
  assign devState  = dev_state_q;

endmodule

// File: doc/usb_std_req_ctrl.md
Name: usb_std_req_ctrl

Overview:
- Control-endpoint (EP0) sequencer for USB standard device requests.
- Collects the 8-byte SETUP payload (SetupPacket layout, byte 0 = bmRequestType) and decodes bRequest/bmRequestType.
- Owns device state (DEFAULT/ADDRESS/CONFIGURED), device address and configuration value.
- Either streams short IN replies itself, hands GET_DESCRIPTOR to the descriptor ROM reader, or signals a Request Error (STALL) to the EP0 transaction layer.

Parameters:
- CONFIG_VALUE, 1, only supported bConfigurationValue; any other non-zero value stalls.
- SELF_POWERED, 0, value returned in GET_STATUS(device) bit 0.

Ports:
- clk48  in  1  system clock
- rst  in  1  synchronous active-high reset
- usbRst  in  1  bus reset seen; same effect as rst on device state
- setupValid  in  1  setupByte valid this cycle
- setupByte  in  8  SETUP data byte, wire order (LSB of multibyte fields first)
- setupEnd  in  1  SETUP packet complete and CRC ok; pulses one cycle after the last byte
- inValid  out  1  reply byte valid
- inReady  in  1  consumer accepts the reply byte
- inByte  out  8  reply byte
- inLast  out  1  final reply byte
- descReq  out  1  level, descriptor fetch active
- descType  out  8  wValue[15:8]
- descIndex  out  8  wValue[7:0]
- descLen  out  16  wLength
- descDone  in  1  descriptor reader finished; 1-cycle pulse
- descErr  in  1  descriptor does not exist; 1-cycle pulse
- statusDone  in  1  status stage ACKed; 1-cycle pulse
- reqStall  out  1  level, STALL the current control transfer until the next setupEnd
- devAddr  out  7  active device address
- devConfig  out  8  active configuration value
- devState  out  2  0 = DEFAULT, 1 = ADDRESS, 2 = CONFIGURED

Behaviour:
- Reset (rst or usbRst): FSM to IDLE. All outputs 0: devAddr=0, devConfig=0, devState=DEFAULT, reqStall=0, descReq=0, inValid=0.
- Byte counter (3 bits): increments on setupValid; byte k is stored at little-endian position k.
  - setupEnd with count≠8 → reqStall=1, go to IDLE.
  - setupEnd always aborts any in-progress request and restarts decode. A new SETUP overrides the old one.
- FSM states:
  - IDLE: clear counter on setupEnd; setupValid → COLLECT.
  - COLLECT: on setupEnd with 8 bytes → DECODE, registered one cycle later.
  - DECODE: single cycle; branches on the request (see decode rules below).
  - REPLY: emits reply bytes with valid/ready.
    - inValid stays high and inByte stays stable until inReady. A byte transfers when inValid&inReady.
    - Reply length = min(natural length, wLength). wLength=0 skips REPLY.
    - inLast is asserted on the final byte.
    - After the last transfer → WAIT_STATUS.
  - DESC: descReq=1. descDone → WAIT_STATUS; descErr → reqStall=1, IDLE.
  - WAIT_STATUS: statusDone → APPLY.
  - APPLY: single cycle; commits pending address/config, then → IDLE.
- Decode rules (non-standard type → STALL):
  - SET_ADDRESS (0x00/5): wValue>127 or state CONFIGURED → STALL.
    - Otherwise pendAddr=wValue[6:0] and go to WAIT_STATUS.
    - In APPLY: devAddr=pendAddr; devState = ADDRESS if pendAddr≠0, else DEFAULT.
    - devAddr must not change before statusDone.
  - SET_CONFIGURATION (0x00/9): only valid in ADDRESS or CONFIGURED.
    - wValue[7:0] ∈ {0, CONFIG_VALUE} else STALL.
    - In APPLY: devConfig=value; devState = CONFIGURED if non-zero, else ADDRESS.
  - GET_CONFIGURATION (0x80/8): 1-byte reply = devConfig.
  - GET_STATUS:
    - Device (0x80): 2 bytes {SELF_POWERED | rwk<<1, 0x00}.
    - Interface (0x81) or endpoint (0x82): 2 bytes 0x00 0x00. Only valid when wIndex=0 or state CONFIGURED, else STALL.
  - GET_DESCRIPTOR (0x80/6) → DESC.
  - CLEAR_FEATURE/SET_FEATURE with ENDPOINT_HALT on endpoint 0: accepted as no-op, go to WAIT_STATUS.
  - All other requests, including TEST_MODE, SET_DESCRIPTOR, GET/SET_INTERFACE and SYNCH_FRAME: STALL.
- reqStall is a level. It is cleared on the next setupEnd.
- Simultaneous setupEnd and statusDone: setupEnd wins; the pending commit is discarded.

Optional Feature:
- REMOTE_WAKEUP_EN defined:
  - Adds flag rwk (reset 0). SET_FEATURE(0x00, DEVICE_REMOTE_WAKEUP) sets it in APPLY; CLEAR_FEATURE clears it in APPLY.
  - GET_STATUS(device) bit 1 = rwk.
  - Adds output remoteWakeupEn (1 bit) = rwk.
- Undefined:
  - rwk is a constant 0 and the port is absent.
  - DEVICE_REMOTE_WAKEUP feature requests STALL.

Test Plan:
- SET_ADDRESS 00 05 2A 00 00 00 00 00 → devAddr stays 0 until statusDone; the cycle after APPLY devAddr=0x2A, devState=1.
- In ADDRESS state, SET_CONFIGURATION wValue=1 then GET_CONFIGURATION wLength=1 → reply byte 0x01 with inLast, devState=2. SET_CONFIGURATION wValue=3 → reqStall=1, devConfig unchanged.
- GET_STATUS device wLength=1, inReady held low 5 cycles → inByte stable, exactly one byte 0x00 (SELF_POWERED=0) with inLast.
- GET_DESCRIPTOR 80 06 00 02 00 00 40 00 → descReq=1, descType=0x02, descIndex=0, descLen=0x0040. descErr → reqStall=1, descReq=0.
- Only 6 bytes before setupEnd → reqStall=1. Next valid 8-byte SETUP → reqStall cleared on its setupEnd.
- SET_ADDRESS pending, usbRst before statusDone → devAddr=0, devState=0, FSM in IDLE. A later statusDone has no effect.
